// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA timing generator: issues pixel coordinates to a pixel source, then registers
// sync/blank/RGB one pixel later. Define VGA_TEST_PATTERN_EN to replace pix_R/G/B with colour bars.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [9:0] pix_R,
    input  logic [9:0] pix_G,
    input  logic [9:0] pix_B,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       pix_req,
    output logic       frame_start,
    output logic       VGA_CLK,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK,
    output logic       VGA_SYNC,
    output logic [9:0] VGA_R,
    output logic [9:0] VGA_G,
    output logic [9:0] VGA_B
);

    localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
    localparam logic [9:0] H_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] HS_FST  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FST  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic       pe_q;
    logic       vga_clk_q;
    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;
    logic [9:0] pix_x_q, pix_y_q;
    logic       pix_req_q, pix_req_d;
    logic       frame_start_q, frame_start_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       blank_q;
    logic [9:0] r_q, r_d;
    logic [9:0] g_q, g_d;
    logic [9:0] b_q, b_d;

    // Counters and stage 0 only move on pixel ticks (pe_q high).
    always_comb begin
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        pix_req_d     = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        frame_start_d = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
        if (pe_q) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = 10'd0;
                v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;
    logic [2:0] bar_c;

    // Smallest bar boundary above pix_x wins; yields colour code 7-k without a divider.
    always_comb begin
        bar_c = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (pix_x_q < 10'((k + 1) * BAR_W)) bar_c = 3'(7 - k);
        end
    end
`endif

    always_comb begin
        hs_d = !((pix_x_q >= HS_FST) && (pix_x_q <= HS_LST));
        vs_d = !((pix_y_q >= VS_FST) && (pix_y_q <= VS_LST));
        r_d  = 10'd0;
        g_d  = 10'd0;
        b_d  = 10'd0;
        if (pix_req_q) begin
`ifdef VGA_TEST_PATTERN_EN
            r_d = {10{bar_c[2]}};
            g_d = {10{bar_c[1]}};
            b_d = {10{bar_c[0]}};
`else
            r_d = pix_R;
            g_d = pix_G;
            b_d = pix_B;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pe_q          <= 1'b0;
            vga_clk_q     <= 1'b0;
            h_cnt_q       <= 10'd0;
            v_cnt_q       <= 10'd0;
            pix_x_q       <= 10'd0;
            pix_y_q       <= 10'd0;
            pix_req_q     <= 1'b0;
            frame_start_q <= 1'b0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            blank_q       <= 1'b0;
            r_q           <= 10'd0;
            g_q           <= 10'd0;
            b_q           <= 10'd0;
        end else begin
            pe_q      <= ~pe_q;
            vga_clk_q <= ~pe_q;
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            if (pe_q) begin
                // Stage 1 consumes stage 0's previous values before they are overwritten.
                hs_q          <= hs_d;
                vs_q          <= vs_d;
                blank_q       <= pix_req_q;
                r_q           <= r_d;
                g_q           <= g_d;
                b_q           <= b_d;
                pix_x_q       <= h_cnt_q;
                pix_y_q       <= v_cnt_q;
                pix_req_q     <= pix_req_d;
                frame_start_q <= frame_start_d;
            end
        end
    end

    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign pix_req     = pix_req_q;
    assign frame_start = frame_start_q;
    assign VGA_CLK     = vga_clk_q;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK   = blank_q;
    assign VGA_SYNC    = 1'b0;
    assign VGA_R       = r_q;
    assign VGA_G       = g_q;
    assign VGA_B       = b_q;

endmodule
